fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
Round-robin arbiter that shares the write port of one synchronous FIFO among NUM_REQ requesters. It grants one requester at a time for a burst of up to MAX_BURST words. It drives the FIFO's write_to_stack/Data_in, honours stack_full back-pressure and returns a per-word ack to the granted requester. It sits between producer blocks and the FIFO; the FIFO read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..4)
OWNER_WIDTH, 2, index width; NUM_REQ <= 2**OWNER_WIDTH
DATA_WIDTH, 8, word width, equals FIFO stack_width
MAX_BURST, 4, max words written per grant (>=1)
BURST_CNT_WIDTH, 3, burst counter width; must hold MAX_BURST

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
req  input  NUM_REQ  per-requester level request; bit i high = word on req_data slice i valid
req_data  input  NUM_REQ*DATA_WIDTH  packed words; slice i = bits [i*DATA_WIDTH +: DATA_WIDTH]
stack_full  input  1  FIFO full flag
grant  output  NUM_REQ  registered one-hot owner; 0 when idle
ack  output  NUM_REQ  combinational; bit owner high in the cycle its word is written
write_to_stack  output  1  combinational FIFO write strobe
Data_in  output  DATA_WIDTH  combinational FIFO write data
busy  output  1  high in GRANT state

Behaviour:
- FSM states: IDLE, GRANT. Registers: state, owner (OWNER_WIDTH), last (OWNER_WIDTH), burst_cnt.
- Reset (rst==0 at edge): state=IDLE, owner=0, last=NUM_REQ-1, burst_cnt=0. Resulting outputs: grant=0, busy=0. While rst==0, write_to_stack=0 and ack=0 regardless of state. Reset mid-burst abandons the burst, and no word is written in that cycle.
- Round-robin pick: the first i with req[i]==1, searching last+1, last+2, ... modulo NUM_REQ. Indices >= NUM_REQ are skipped.
- IDLE: if any req bit is set, the next edge sets state=GRANT, owner=pick, burst_cnt=0. Grant latency is 1 cycle from the first req. No write happens in IDLE.
- GRANT: grant = one-hot(owner), Data_in = req_data slice owner. In IDLE, Data_in=0.
- GRANT: write_to_stack = req[owner] & ~stack_full. ack[owner] = write_to_stack; all other ack bits are 0.
- A write occurs on an edge where write_to_stack==1. On that edge burst_cnt increments.
- Exit from GRANT on an edge where (a) a write occurs with burst_cnt==MAX_BURST-1, or (b) req[owner]==0.
  - On exit: last=owner, then re-pick with the updated last.
  - If any req is set, stay in GRANT with the new owner and burst_cnt=0. This is a same-edge handover with no bubble; it may re-grant the same requester if it is the only one requesting.
  - If no req is set, go to IDLE.
- stack_full==1 in GRANT: no write, no ack, grant held, burst_cnt frozen. Stall is unbounded.
- Requester contract: hold req and data until ack. Dropping req releases the grant; no word is written in that cycle.

Optional Feature:
Macro FIFO_ARB_STALL_CNT_EN.
- Defined: adds output stall_cycles [15:0]. It increments on every edge in GRANT where req[owner]==1 and stack_full==1, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
1. rst=0 for 2 cycles with req=4'b1111 -> grant=0, write_to_stack=0, ack=0. rst=1 -> grant=4'b0001 on the next edge, with the first write in that cycle.
2. Only req[2] held with data 8'hA0..8'hA5 and ack-driven advance, stack_full=0 -> grant=4'b0100 throughout. Six writes land on 6 consecutive cycles; at the re-grant after 4 words there is no bubble.
3. req=4'b1111 constant -> grant sequence 0001,0010,0100,1000,0001. Each owner gets exactly 4 consecutive writes, and there are no idle cycles.
4. Mid-burst, after 2 words of req[0], stack_full=1 for 3 cycles -> write_to_stack=0, ack=0, grant held. After release, exactly 2 more words, then handover. With FIFO_ARB_STALL_CNT_EN, stall_cycles=3.
5. req[1] owner drops req after 1 word while req[3]=1 -> no write that cycle, grant=4'b1000 on the next edge.
6. rst=0 during burst of req[2] (burst_cnt=2) -> write_to_stack=0 that cycle. On the next edge grant=0 and busy=0, and the first grant after release goes to req 0 if requesting.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_write_arbiter
//  Description : Round-robin arbiter sharing the write port of one synchronous
//                FIFO among NUM_REQ requesters. A requester is granted for a
//                burst of up to MAX_BURST words. Each word is acknowledged in
//                the cycle it is written. stack_full stalls the burst without
//                releasing the grant. At a burst boundary the grant passes to
//                the next requester on the same edge, with no idle cycle.
//                Optional feature macro: FIFO_ARB_STALL_CNT_EN adds a
//                saturating 16-bit stall_cycles output.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int OWNER_WIDTH     = 2,
    parameter int DATA_WIDTH      = 8,
    parameter int MAX_BURST       = 4,
    parameter int BURST_CNT_WIDTH = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          stack_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          write_to_stack,
    output logic [DATA_WIDTH-1:0]         Data_in,
    output logic                          busy
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cycles
`endif
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // Burst counter value at which the word being written is the last of the burst
    localparam logic [BURST_CNT_WIDTH-1:0] c_last_beat = BURST_CNT_WIDTH'(MAX_BURST - 1);

    state_t                     r_state;
    logic [OWNER_WIDTH-1:0]     r_owner;
    logic [OWNER_WIDTH-1:0]     r_last;
    logic [BURST_CNT_WIDTH-1:0] r_burst_cnt;

    state_t                     w_state_nxt;
    logic [OWNER_WIDTH-1:0]     w_owner_nxt;
    logic [OWNER_WIDTH-1:0]     w_last_nxt;
    logic [BURST_CNT_WIDTH-1:0] w_burst_cnt_nxt;

    logic [OWNER_WIDTH-1:0]     w_pick_base;
    logic [OWNER_WIDTH-1:0]     w_pick;
    logic                       w_pick_found;
    logic                       w_any_req;
    logic                       w_owner_req;
    logic [DATA_WIDTH-1:0]      w_owner_data;
    logic                       w_in_grant;
    logic                       w_write;
    logic                       w_exit;

    assign w_any_req  = |req;
    assign w_in_grant = (r_state == S_GRANT);

    // Select the owner's request bit and data word without indexing past NUM_REQ
    always_comb begin
        w_owner_req  = 1'b0;
        w_owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_owner == OWNER_WIDTH'(i)) begin
                w_owner_req  = req[i];
                w_owner_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Round-robin search starting after the base index; on a grant exit the
    // base is the current owner, which becomes the new "last" on that edge
    always_comb begin
        w_pick_base  = (r_state == S_IDLE) ? r_last : r_owner;
        w_pick       = '0;
        w_pick_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = (int'(w_pick_base) + k) % NUM_REQ;
            if (!w_pick_found && req[idx]) begin
                w_pick       = OWNER_WIDTH'(idx);
                w_pick_found = 1'b1;
            end
        end
    end

    // A word is written only while granted, requested, not full and out of reset
    assign w_write = w_in_grant & w_owner_req & ~stack_full & rst;

    // Burst ends on its last written word or when the owner drops its request
    assign w_exit = (w_write && (r_burst_cnt == c_last_beat)) || !w_owner_req;

    assign write_to_stack = w_write;
    assign Data_in        = w_in_grant ? w_owner_data : '0;
    assign busy           = w_in_grant;

    // One-hot grant and per-word ack decoded from the registered owner
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_owner_decode
            assign grant[g] = w_in_grant && (r_owner == OWNER_WIDTH'(g));
            assign ack[g]   = w_write    && (r_owner == OWNER_WIDTH'(g));
        end
    endgenerate

    // Next-state logic: grant on request, count words, hand over at burst end
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_last_nxt      = r_last;
        w_burst_cnt_nxt = r_burst_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt     = S_GRANT;
                    w_owner_nxt     = w_pick;
                    w_burst_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                if (w_exit) begin
                    w_last_nxt      = r_owner;
                    w_burst_cnt_nxt = '0;
                    if (w_any_req) begin
                        w_state_nxt = S_GRANT;
                        w_owner_nxt = w_pick;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_write) begin
                    w_burst_cnt_nxt = r_burst_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_burst_cnt_nxt = '0;
            end
        endcase
    end

    // State registers; reset leaves "last" at the top index so requester 0 wins first
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_owner     <= '0;
            r_last      <= OWNER_WIDTH'(NUM_REQ - 1);
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_last      <= w_last_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cycles;

    // Count granted cycles blocked only by a full FIFO, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cycles <= '0;
        end else if (w_in_grant && w_owner_req && stack_full && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_write_arbiter
//  Description : Self-checking bench for fifo_write_arbiter. Producers hold a
//                word until acked; a scoreboard holds the expected order of
//                FIFO writes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic              stack_full;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     ack;
    logic              write_to_stack;
    logic [DW-1:0]     Data_in;
    logic              busy;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]       stall_cycles;
`endif

    fifo_write_arbiter #(
        .NUM_REQ         (NR),
        .OWNER_WIDTH     (2),
        .DATA_WIDTH      (DW),
        .MAX_BURST       (4),
        .BURST_CNT_WIDTH (3)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .stack_full     (stack_full),
        .grant          (grant),
        .ack            (ack),
        .write_to_stack (write_to_stack),
        .Data_in        (Data_in),
`ifdef FIFO_ARB_STALL_CNT_EN
        .stall_cycles   (stall_cycles),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    who;
        logic [DW-1:0] data;
    } sb_t;

    sb_t          sb[$];
    logic [DW-1:0] pmem [NR][32];
    int           phead [NR];
    int           plen  [NR];

    int n_checks;
    int n_fail;

    logic [NR-1:0] obs_grant;
    logic [NR-1:0] obs_ack;
    logic          obs_write;
    logic [DW-1:0] obs_data;
    logic          obs_busy;

    sb_t           exp;
    logic [NR-1:0] oh;

    task automatic load(input int who, input logic [DW-1:0] d);
        pmem[who][plen[who]] = d;
        plen[who]++;
    endtask

    task automatic push_exp(input int who, input logic [DW-1:0] d);
        sb.push_back({2'(who), d});
    endtask

    // Each producer presents its oldest unacked word
    task automatic apply_inputs();
        for (int i = 0; i < NR; i++) begin
            if (phead[i] < plen[i]) begin
                req[i]               = 1'b1;
                req_data[i*DW +: DW] = pmem[i][phead[i]];
            end else begin
                req[i]               = 1'b0;
                req_data[i*DW +: DW] = '0;
            end
        end
    endtask

    // Sample outputs mid-cycle, then advance producers just after the edge
    task automatic tick();
        @(negedge clk);
        obs_grant = grant;
        obs_ack   = ack;
        obs_write = write_to_stack;
        obs_data  = Data_in;
        obs_busy  = busy;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (obs_ack[i] && (phead[i] < plen[i])) phead[i]++;
        end
        apply_inputs();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NR; i++) begin
            load(i, 8'h10 + 8'(i));
            push_exp(i, 8'h10 + 8'(i));
        end
        apply_inputs();
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++;
            if (obs_grant !== 4'b0000 || obs_write !== 1'b0 || obs_ack !== 4'b0000 || obs_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold: grant=%b write=%b ack=%b busy=%b, required all 0", obs_grant, obs_write, obs_ack, obs_busy);
            end
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (obs_grant !== 4'b0000 || obs_write !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: grant=%b write=%b, required 0000/0", obs_grant, obs_write);
        end
        for (int k = 0; k < NR; k++) begin
            tick();
            n_checks++;
            exp = sb.pop_front();
            oh  = 4'b0001 << exp.who;
            if (obs_write !== 1'b1 || obs_data !== exp.data || obs_ack !== oh || obs_grant !== oh) begin
                n_fail++;
                $display("FAIL reset_word%0d: write=%b data=%h ack=%b grant=%b, required write=1 data=%h ack=grant=%b", k, obs_write, obs_data, obs_ack, obs_grant, exp.data, oh);
            end
            if (k < NR - 1) begin
                tick();
                n_checks++;
                if (obs_write !== 1'b0 || obs_ack !== 4'b0000 || obs_grant !== oh) begin
                    n_fail++;
                    $display("FAIL reset_drop%0d: write=%b ack=%b grant=%b, required 0/0000/%b", k, obs_write, obs_ack, obs_grant, oh);
                end
            end
        end
    endtask

    task automatic test_idle(input string name);
        tick();
        tick();
        n_checks++;
        if (obs_busy !== 1'b0 || obs_grant !== 4'b0000 || obs_write !== 1'b0 || Data_in !== 8'h00) begin
            n_fail++;
            $display("FAIL %s_idle: busy=%b grant=%b write=%b data=%h, required 0/0000/0/00", name, obs_busy, obs_grant, obs_write, Data_in);
        end
    endtask

    task automatic test_round_robin();
        test_idle("rr");
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < ((i == 0) ? 8 : 4); k++) load(i, 8'((i << 4) | k));
        end
        for (int i = 0; i < NR; i++) begin
            for (int k = 0; k < 4; k++) push_exp(i, 8'((i << 4) | k));
        end
        for (int k = 4; k < 8; k++) push_exp(0, 8'(k));
        apply_inputs();
        tick();
        n_checks++;
        if (obs_write !== 1'b0 || obs_grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL rr_first_idle: write=%b grant=%b, required 0/0000", obs_write, obs_grant);
        end
        for (int w = 0; w < 20; w++) begin
            tick();
            n_checks++;
            exp = sb.pop_front();
            oh  = 4'b0001 << exp.who;
            if (obs_write !== 1'b1 || obs_data !== exp.data || obs_ack !== oh || obs_grant !== oh) begin
                n_fail++;
                $display("FAIL rr_word%0d: write=%b data=%h ack=%b grant=%b, required write=1 data=%h ack=grant=%b", w, obs_write, obs_data, obs_ack, obs_grant, exp.data, oh);
            end
        end
    endtask

    task automatic test_single_burst();
        test_idle("single");
        for (int k = 0; k < 6; k++) begin
            load(2, 8'hA0 + 8'(k));
            push_exp(2, 8'hA0 + 8'(k));
        end
        apply_inputs();
        tick();
        n_checks++;
        if (obs_write !== 1'b0 || obs_grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL single_latency: write=%b grant=%b, required 0/0000", obs_write, obs_grant);
        end
        for (int w = 0; w < 6; w++) begin
            tick();
            n_checks++;
            exp = sb.pop_front();
            if (obs_write !== 1'b1 || obs_data !== exp.data || obs_ack !== 4'b0100 || obs_grant !== 4'b0100) begin
                n_fail++;
                $display("FAIL single_word%0d: write=%b data=%h ack=%b grant=%b, required write=1 data=%h ack=grant=0100", w, obs_write, obs_data, obs_ack, obs_grant, exp.data);
            end
        end
    endtask

    task automatic test_stall();
        test_idle("stall");
        for (int k = 0; k < 4; k++) begin
            load(0, 8'hC0 + 8'(k));
            push_exp(0, 8'hC0 + 8'(k));
        end
        push_exp(1, 8'hD0);
        apply_inputs();
        tick();
        for (int w = 0; w < 2; w++) begin
            tick();
            n_checks++;
            exp = sb.pop_front();
            if (obs_write !== 1'b1 || obs_data !== exp.data || obs_ack !== 4'b0001 || obs_grant !== 4'b0001) begin
                n_fail++;
                $display("FAIL stall_pre%0d: write=%b data=%h ack=%b grant=%b, required write=1 data=%h ack=grant=0001", w, obs_write, obs_data, obs_ack, obs_grant, exp.data);
            end
        end
        stack_full = 1'b1;
        load(1, 8'hD0);
        apply_inputs();
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs_write !== 1'b0 || obs_ack !== 4'b0000 || obs_grant !== 4'b0001) begin
                n_fail++;
                $display("FAIL stall_hold%0d: write=%b ack=%b grant=%b, required 0/0000/0001", c, obs_write, obs_ack, obs_grant);
            end
        end
        stack_full = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick();
            n_checks++;
            exp = sb.pop_front();
            oh  = 4'b0001 << exp.who;
            if (obs_write !== 1'b1 || obs_data !== exp.data || obs_ack !== oh || obs_grant !== oh) begin
                n_fail++;
                $display("FAIL stall_post%0d: write=%b data=%h ack=%b grant=%b, required write=1 data=%h ack=grant=%b", w, obs_write, obs_data, obs_ack, obs_grant, exp.data, oh);
            end
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 16'd3) begin
            n_fail++;
            $display("FAIL stall_count: stall_cycles=%0d, required 3", stall_cycles);
        end
`endif
    endtask

    task automatic test_drop();
        test_idle("drop");
        load(1, 8'h51);
        push_exp(1, 8'h51);
        apply_inputs();
        tick();
        load(3, 8'h71);
        load(3, 8'h72);
        push_exp(3, 8'h71);
        push_exp(3, 8'h72);
        apply_inputs();
        tick();
        n_checks++;
        exp = sb.pop_front();
        if (obs_write !== 1'b1 || obs_data !== exp.data || obs_grant !== 4'b0010 || obs_ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_first: write=%b data=%h grant=%b ack=%b, required 1/%h/0010/0010", obs_write, obs_data, obs_grant, obs_ack, exp.data);
        end
        tick();
        n_checks++;
        if (obs_write !== 1'b0 || obs_ack !== 4'b0000 || obs_grant !== 4'b0010) begin
            n_fail++;
            $display("FAIL drop_release: write=%b ack=%b grant=%b, required 0/0000/0010", obs_write, obs_ack, obs_grant);
        end
        for (int w = 0; w < 2; w++) begin
            tick();
            n_checks++;
            exp = sb.pop_front();
            if (obs_write !== 1'b1 || obs_data !== exp.data || obs_grant !== 4'b1000 || obs_ack !== 4'b1000) begin
                n_fail++;
                $display("FAIL drop_next%0d: write=%b data=%h grant=%b ack=%b, required 1/%h/1000/1000", w, obs_write, obs_data, obs_grant, obs_ack, exp.data);
            end
        end
    endtask

    task automatic test_reset_midburst();
        test_idle("midrst");
        for (int k = 0; k < 4; k++) load(2, 8'hE0 + 8'(k));
        push_exp(2, 8'hE0);
        push_exp(2, 8'hE1);
        apply_inputs();
        tick();
        for (int w = 0; w < 2; w++) begin
            tick();
            n_checks++;
            exp = sb.pop_front();
            if (obs_write !== 1'b1 || obs_data !== exp.data || obs_grant !== 4'b0100) begin
                n_fail++;
                $display("FAIL midrst_pre%0d: write=%b data=%h grant=%b, required 1/%h/0100", w, obs_write, obs_data, obs_grant, exp.data);
            end
        end
        rst = 1'b0;
        load(0, 8'h0F);
        push_exp(0, 8'h0F);
        push_exp(2, 8'hE2);
        push_exp(2, 8'hE3);
        apply_inputs();
        tick();
        n_checks++;
        if (obs_write !== 1'b0 || obs_ack !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_nowrite: write=%b ack=%b, required 0/0000", obs_write, obs_ack);
        end
        tick();
        n_checks++;
        if (obs_grant !== 4'b0000 || obs_busy !== 1'b0 || obs_write !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_cleared: grant=%b busy=%b write=%b, required 0000/0/0", obs_grant, obs_busy, obs_write);
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_checks++;
        if (stall_cycles !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_stall_count: stall_cycles=%0d, required 0", stall_cycles);
        end
`endif
        rst = 1'b1;
        tick();
        for (int w = 0; w < 4; w++) begin
            tick();
            n_checks++;
            if (w == 1) begin
                if (obs_write !== 1'b0 || obs_grant !== 4'b0001) begin
                    n_fail++;
                    $display("FAIL midrst_bubble: write=%b grant=%b, required 0/0001", obs_write, obs_grant);
                end
            end else begin
                exp = sb.pop_front();
                oh  = 4'b0001 << exp.who;
                if (obs_write !== 1'b1 || obs_data !== exp.data || obs_ack !== oh || obs_grant !== oh) begin
                    n_fail++;
                    $display("FAIL midrst_post%0d: write=%b data=%h ack=%b grant=%b, required write=1 data=%h ack=grant=%b", w, obs_write, obs_data, obs_ack, obs_grant, exp.data, oh);
                end
            end
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d entries, required 0", sb.size());
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        req        = '0;
        req_data   = '0;
        stack_full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            phead[i] = 0;
            plen[i]  = 0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_round_robin();
        test_single_burst();
        test_stall();
        test_drop();
        test_reset_midburst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
